// File: rtl/led7_scan.sv
// Two-digit 7-segment scanner: per-frame snapshot of both segment bytes,
// alternating digit slots with a blank phase 0 and 4-bit PWM brightness.
module led7_scan #(
    parameter int PWM_STEP       = 3125,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] seg_hi,
    input  logic [7:0] seg_lo,
    input  logic [3:0] bright,
    output logic [7:0] seg,
    output logic [1:0] dig,
    output logic       frame_tick
);

    localparam int STEP_W = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PWM_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    // XOR masks: an inactive line equals the mask, a lit line is data ^ mask.
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [1:0] DIG_OFF = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;

    logic [STEP_W-1:0] step, step_nxt;
    logic [3:0]        phase, phase_nxt;
    logic              digit, digit_nxt;
    logic [7:0]        snap_hi, snap_lo;
    logic              step_wrap, phase_wrap, frame_wrap;
    logic              snap_take, lit;
    logic [7:0]        seg_nxt;
    logic [1:0]        dig_nxt;
    logic              tick_nxt;

    always_comb begin
        step_wrap  = (step == STEP_LAST);
        phase_wrap = step_wrap && (phase == 4'hF);
        frame_wrap = phase_wrap && digit;
        snap_take  = en && !digit && (phase == 4'd0) && (step == '0);
        // Phase 0 stays dark in every slot so the digit switch never ghosts.
        lit        = en && (phase != 4'd0) && (phase <= bright);
    end

    always_comb begin
        step_nxt  = '0;
        phase_nxt = 4'd0;
        digit_nxt = 1'b0;
        if (en) begin
            step_nxt  = step_wrap ? '0 : step + STEP_ONE;
            phase_nxt = step_wrap ? phase + 4'd1 : phase;
            digit_nxt = phase_wrap ? ~digit : digit;
        end
    end

    always_comb begin
        seg_nxt  = SEG_OFF;
        dig_nxt  = DIG_OFF;
        tick_nxt = en && frame_wrap;
        if (lit) begin
            seg_nxt = (digit ? snap_hi : snap_lo) ^ SEG_OFF;
            dig_nxt = (digit ? 2'b10 : 2'b01) ^ DIG_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step  <= '0;
            phase <= 4'd0;
            digit <= 1'b0;
        end else begin
            step  <= step_nxt;
            phase <= phase_nxt;
            digit <= digit_nxt;
        end
    end

    // Snapshots survive en=0 so a re-enable shows consistent data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_hi <= 8'h00;
            snap_lo <= 8'h00;
        end else if (snap_take) begin
            snap_hi <= seg_hi;
            snap_lo <= seg_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF;
            dig        <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            dig        <= dig_nxt;
            frame_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_led7_scan.sv
// Self-checking bench for led7_scan: frame-position reference model plus
// directed literal checks for reset, alternation, brightness, tearing, en, async reset.
module tb_led7_scan;

    localparam int P     = 4;
    localparam int SLOT  = 16 * P;
    localparam int FRAME = 32 * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] seg_hi = 8'h00;
    logic [7:0] seg_lo = 8'h00;
    logic [3:0] bright = 4'd0;
    logic [7:0] seg;
    logic [1:0] dig;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    led7_scan #(
        .PWM_STEP      (P),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .seg_hi    (seg_hi),
        .seg_lo    (seg_lo),
        .bright    (bright),
        .seg       (seg),
        .dig       (dig),
        .frame_tick(frame_tick)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: output word {tick, dig, seg} expected after each edge
    logic [10:0] exp_q[$];
    int          pos;
    int          m_d, m_ph;
    logic        m_lit;
    logic [7:0]  m_hi, m_lo;
    logic [10:0] m_e, m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos = 0;
            m_hi = 8'h00;
            m_lo = 8'h00;
            exp_q.delete();
            exp_q.push_back({1'b0, 2'b11, 8'hFF});
        end else begin
            if (!en) begin
                pos = 0;
                m_e = {1'b0, 2'b11, 8'hFF};
            end else begin
                if (pos == 0) begin
                    m_hi = seg_hi;
                    m_lo = seg_lo;
                end
                m_d   = pos / SLOT;
                m_ph  = (pos % SLOT) / P;
                m_lit = (m_ph != 0) && (m_ph <= int'(bright));
                m_e   = {(pos == FRAME - 1),
                         m_lit ? ((m_d == 1) ? 2'b01 : 2'b10) : 2'b11,
                         m_lit ? ~((m_d == 1) ? m_hi : m_lo) : 8'hFF};
                pos   = (pos + 1) % FRAME;
            end
            exp_q.push_back(m_e);
        end
    end

    // scoreboard compare on every falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_c = exp_q.pop_front();
            check("model_seg", 32'(seg), 32'(m_c[7:0]));
            check("model_dig", 32'(dig), 32'(m_c[9:8]));
            check("model_tick", 32'(frame_tick), 32'(m_c[10]));
        end
    end

    // driver tasks
    task automatic restart();
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    task automatic count_win(input int n, output int lit, output int ticks);
        lit = 0;
        ticks = 0;
        repeat (n) begin
            @(negedge clk);
            if (dig !== 2'b11) lit++;
            if (frame_tick === 1'b1) ticks++;
        end
    endtask

    int lit_n, tick_n, tick_a, tick_b;

    initial begin
        // reset held while inputs toggle
        en = 1'b1;
        bright = 4'd15;
        seg_lo = 8'h3F;
        repeat (6) begin
            @(negedge clk);
            check("rst_seg", 32'(seg), 32'h0FF);
            check("rst_dig", 32'(dig), 32'h3);
            check("rst_tick", 32'(frame_tick), 32'h0);
            seg_hi = 8'($urandom);
            seg_lo = 8'($urandom);
            bright = 4'($urandom);
            en     = 1'($urandom);
        end
        en = 1'b1;
        bright = 4'd15;
        seg_lo = 8'h3F;
        seg_hi = 8'h00;
        rst_n = 1'b1;
        for (int k = 1; k <= SLOT; k++) begin
            @(negedge clk);
            if (k <= 4) begin
                check("rel_blank_seg", 32'(seg), 32'h0FF);
                check("rel_blank_dig", 32'(dig), 32'h3);
            end else begin
                check("rel_lit_seg", 32'(seg), 32'h0C0);
                check("rel_lit_dig", 32'(dig), 32'h2);
            end
        end

        // digit alternation and frame tick
        seg_hi = 8'h06;
        seg_lo = 8'h5B;
        restart();
        tick_a = 0;
        tick_b = 0;
        for (int k = 1; k <= 2 * FRAME; k++) begin
            @(negedge clk);
            if (k == 10) begin
                check("alt_lo_seg", 32'(seg), 32'h0A4);
                check("alt_lo_dig", 32'(dig), 32'h2);
            end
            if (k == 100) begin
                check("alt_hi_seg", 32'(seg), 32'h0F9);
                check("alt_hi_dig", 32'(dig), 32'h1);
            end
            if (k == FRAME) check("tick_at_end", 32'(frame_tick), 32'h1);
            if (frame_tick === 1'b1) begin
                if (k <= FRAME) tick_a++;
                else tick_b++;
            end
        end
        check("ticks_frame1", 32'(tick_a), 32'd1);
        check("ticks_frame2", 32'(tick_b), 32'd1);

        // brightness
        bright = 4'd4;
        restart();
        count_win(SLOT, lit_n, tick_n);
        check("bright4_lit", 32'(lit_n), 32'd16);
        bright = 4'd0;
        restart();
        count_win(2 * FRAME, lit_n, tick_n);
        check("bright0_lit", 32'(lit_n), 32'd0);
        bright = 4'd15;
        restart();
        count_win(SLOT, lit_n, tick_n);
        check("bright15_lit", 32'(lit_n), 32'd60);

        // tearing: mid-frame change waits for the next snapshot
        seg_lo = 8'h3F;
        restart();
        repeat (20) @(negedge clk);
        seg_lo = 8'h06;
        repeat (10) @(negedge clk);
        check("tear_old_30", 32'(seg), 32'h0C0);
        repeat (34) @(negedge clk);
        check("tear_old_64", 32'(seg), 32'h0C0);
        repeat (68) @(negedge clk);
        check("tear_gap_dig", 32'(dig), 32'h3);
        @(negedge clk);
        check("tear_new_seg", 32'(seg), 32'h0F9);
        check("tear_new_dig", 32'(dig), 32'h2);

        // en drop at phase 7, then re-raise
        restart();
        repeat (29) @(negedge clk);
        en = 1'b0;
        seg_lo = 8'h6D;
        @(negedge clk);
        check("en_off_seg", 32'(seg), 32'h0FF);
        check("en_off_dig", 32'(dig), 32'h3);
        count_win(200, lit_n, tick_n);
        check("en_off_lit", 32'(lit_n), 32'd0);
        check("en_off_ticks", 32'(tick_n), 32'd0);
        en = 1'b1;
        repeat (4) @(negedge clk);
        check("en_on_blank", 32'(dig), 32'h3);
        @(negedge clk);
        check("en_on_seg", 32'(seg), 32'h092);
        check("en_on_dig", 32'(dig), 32'h2);

        // async reset while lit
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_seg", 32'(seg), 32'h0FF);
        check("async_dig", 32'(dig), 32'h3);
        seg_lo = 8'h5B;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("async_rel_blank", 32'(dig), 32'h3);
        @(negedge clk);
        check("async_rel_seg", 32'(seg), 32'h0A4);
        check("async_rel_dig", 32'(dig), 32'h2);

        // randomized run against the model
        repeat (3000) begin
            @(negedge clk);
            seg_hi = 8'($urandom);
            seg_lo = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bright = 4'($urandom_range(0, 15));
            en = ($urandom_range(0, 63) != 0);
        end
        en = 1'b1;
        repeat (2) @(negedge clk);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
